// File: rtl/uart_nbit_tx.sv
// uart_nbit_tx
//   Parametrised UART transmitter. Serialises NCH parallel 1-bit channels
//   (ch0 first) as one frame: start bit, NCH data bits, optional parity bit,
//   and 1 or 2 stop bits. Frames are launched periodically while uart_start
//   is high, or singly on a tx_req pulse while uart_start is low.
//
// Ports
//   sys_clk     in   system clock
//   sys_reset   in   synchronous active-high reset
//   uart_start  in   level: periodic transmission enable
//   tx_req      in   pulse: single-frame request (ignored while uart_start=1)
//   in_data     in   NCH channel bits, sampled at frame launch
//   uart_txd    out  serial output, idle high (registered)
//   tx_busy     out  high while a frame is on the line
//   tx_sample   out  1-cycle pulse on the cycle in_data is latched
//   uart_done   out  1-cycle pulse on the final cycle of the last stop bit
//   tx_overrun  out  sticky: a launch request arrived while busy
module uart_nbit_tx #(
  parameter int NCH          = 2,
  parameter int CLKS_PER_BIT = 576,
  parameter int PERIOD_BITS  = 8,
  parameter int PARITY_EN    = 0,
  parameter int PARITY_ODD   = 0,
  parameter int STOP_BITS    = 1
) (
  input  logic           sys_clk,
  input  logic           sys_reset,
  input  logic           uart_start,
  input  logic           tx_req,
  input  logic [NCH-1:0] in_data,
  output logic           uart_txd,
  output logic           tx_busy,
  output logic           tx_sample,
  output logic           uart_done,
  output logic           tx_overrun
);

  localparam int PERIOD_CLKS = PERIOD_BITS * CLKS_PER_BIT;
  localparam int CW          = $clog2(CLKS_PER_BIT);
  localparam int PW          = $clog2(PERIOD_CLKS);
  localparam int BW          = 4;

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_START  = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_PARITY = 3'd3;
  localparam logic [2:0] S_STOP   = 3'd4;

  logic [2:0]     state_q, state_d;
  logic [CW-1:0]  clk_cnt_q, clk_cnt_d;
  logic [BW-1:0]  bit_cnt_q, bit_cnt_d;
  logic [NCH-1:0] shift_q, shift_d;
  logic           parity_q, parity_d;
  logic           txd_q, txd_d;
  logic           overrun_q, overrun_d;
  logic           start_q, start_d;
  logic [PW-1:0]  period_cnt_q, period_cnt_d;

  logic start_rise, start_fall, period_tc, launch_req, idle, launch;
  logic bit_tick, last_stop;

  // Parity of the channel bits, seeded with the odd/even selection.
  logic [NCH:0] par_chain;
  assign par_chain[0] = (PARITY_ODD != 0);
  for (genvar gi = 0; gi < NCH; gi++) begin : g_par
    assign par_chain[gi+1] = par_chain[gi] ^ in_data[gi];
  end

  assign start_rise = uart_start & ~start_q;
  assign start_fall = ~uart_start & start_q;
  // The rising edge itself launches, so terminal count is only honoured
  // once the counter has been running.
  assign period_tc  = uart_start & ~start_rise &
                      (period_cnt_q == PW'(PERIOD_CLKS - 1));
  // tx_req only counts while the periodic path is disabled.
  assign launch_req = start_rise | period_tc | (tx_req & ~uart_start);
  assign idle       = (state_q == S_IDLE);
  assign launch     = launch_req & idle;
  assign bit_tick   = (clk_cnt_q == CW'(CLKS_PER_BIT - 1));
  assign last_stop  = (state_q == S_STOP) & bit_tick &
                      (bit_cnt_q == BW'(STOP_BITS - 1));

  always_comb begin
    state_d      = state_q;
    clk_cnt_d    = clk_cnt_q;
    bit_cnt_d    = bit_cnt_q;
    shift_d      = shift_q;
    parity_d     = parity_q;
    overrun_d    = overrun_q;
    start_d      = uart_start;
    period_cnt_d = '0;

    if (launch) begin
      state_d   = S_START;
      clk_cnt_d = '0;
      bit_cnt_d = '0;
      shift_d   = in_data;
      parity_d  = par_chain[NCH];
    end else if (!idle) begin
      clk_cnt_d = bit_tick ? '0 : clk_cnt_q + CW'(1);
      if (bit_tick) begin
        case (state_q)
          S_START: begin
            state_d   = S_DATA;
            bit_cnt_d = '0;
          end
          S_DATA: begin
            shift_d = shift_q >> 1;
            if (bit_cnt_q == BW'(NCH - 1)) begin
              bit_cnt_d = '0;
              state_d   = (PARITY_EN != 0) ? S_PARITY : S_STOP;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
          S_PARITY: begin
            state_d   = S_STOP;
            bit_cnt_d = '0;
          end
          S_STOP: begin
            if (last_stop) begin
              state_d   = S_IDLE;
              bit_cnt_d = '0;
            end else begin
              bit_cnt_d = bit_cnt_q + BW'(1);
            end
          end
          default: state_d = S_IDLE;
        endcase
      end
    end

    // Free-running while enabled so launch spacing is independent of the
    // frame length; held at zero whenever uart_start is low.
    if (uart_start && !start_rise) begin
      period_cnt_d = period_tc ? '0 : period_cnt_q + PW'(1);
    end

    // Includes the done cycle: FSM is still in STOP there.
    if (launch_req && !idle) begin
      overrun_d = 1'b1;
    end else if (start_fall) begin
      overrun_d = 1'b0;
    end

    // Line level follows the state being entered so uart_txd is a flop.
    case (state_d)
      S_START:  txd_d = 1'b0;
      S_DATA:   txd_d = shift_d[0];
      S_PARITY: txd_d = parity_d;
      default:  txd_d = 1'b1;
    endcase
  end

  always_ff @(posedge sys_clk) begin
    if (sys_reset) begin
      state_q      <= S_IDLE;
      clk_cnt_q    <= '0;
      bit_cnt_q    <= '0;
      shift_q      <= '0;
      parity_q     <= 1'b0;
      txd_q        <= 1'b1;
      overrun_q    <= 1'b0;
      start_q      <= 1'b0;
      period_cnt_q <= '0;
    end else begin
      state_q      <= state_d;
      clk_cnt_q    <= clk_cnt_d;
      bit_cnt_q    <= bit_cnt_d;
      shift_q      <= shift_d;
      parity_q     <= parity_d;
      txd_q        <= txd_d;
      overrun_q    <= overrun_d;
      start_q      <= start_d;
      period_cnt_q <= period_cnt_d;
    end
  end

  assign uart_txd   = txd_q;
  assign tx_busy    = ~idle;
  assign tx_sample  = launch & ~sys_reset;
  assign uart_done  = last_stop & ~sys_reset;
  assign tx_overrun = overrun_q;

endmodule

// File: tb/tb_uart_nbit_tx.sv
// Bench for uart_nbit_tx: two instances (default framing, and an 8-channel
// even-parity two-stop-bit framing at 4 clocks per bit). Expected frames are
// queued by the stimulus; per-instance monitors decode each frame from the
// line and compare bits, length and done position against the queue.
module tb_uart_nbit_tx;

  localparam int A_CPB = 576;
  localparam int B_CPB = 4;

  typedef struct {
    int bits;
    int len;
  } exp_t;

  logic clk = 1'b0;
  int   cyc = 0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  int n_vec  = 0;
  int n_fail = 0;

  // Instance A: defaults
  logic       rst_a, start_a, req_a;
  logic [1:0] in_a;
  logic       txd_a, busy_a, sample_a, done_a, ovr_a;

  // Instance B: NCH=8, even parity, 2 stop bits, 4 clk/bit
  logic       rst_b, start_b, req_b;
  logic [7:0] in_b;
  logic       txd_b, busy_b, sample_b, done_b, ovr_b;

  uart_nbit_tx dut_a (
    .sys_clk(clk), .sys_reset(rst_a), .uart_start(start_a), .tx_req(req_a),
    .in_data(in_a), .uart_txd(txd_a), .tx_busy(busy_a), .tx_sample(sample_a),
    .uart_done(done_a), .tx_overrun(ovr_a)
  );

  uart_nbit_tx #(
    .NCH(8), .CLKS_PER_BIT(B_CPB), .PERIOD_BITS(12), .PARITY_EN(1),
    .PARITY_ODD(0), .STOP_BITS(2)
  ) dut_b (
    .sys_clk(clk), .sys_reset(rst_b), .uart_start(start_b), .tx_req(req_b),
    .in_data(in_b), .uart_txd(txd_b), .tx_busy(busy_b), .tx_sample(sample_b),
    .uart_done(done_b), .tx_overrun(ovr_b)
  );

  exp_t exp_a[$];
  exp_t exp_b[$];

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // ---------------- monitor A ----------------
  logic        a_cap = 1'b0;
  int          a_cnt, a_done_at;
  logic [15:0] a_bits;
  int          a_samples = 0;
  exp_t        a_e;
  always @(negedge clk) begin
    if (sample_a) a_samples++;
    if (rst_a) begin
      a_cap = 1'b0;
    end else begin
      if (!a_cap && busy_a) begin
        a_cap = 1'b1; a_cnt = 0; a_bits = '0; a_done_at = -1;
      end
      if (a_cap) begin
        if (busy_a) begin
          if ((a_cnt / A_CPB) < 16 && (a_cnt % A_CPB) == A_CPB / 2)
            a_bits[a_cnt / A_CPB] = txd_a;
          if (done_a) a_done_at = a_cnt;
          a_cnt++;
        end else begin
          a_cap = 1'b0;
          $display("frame A: bits=0x%0h len=%0d done_at=%0d", a_bits, a_cnt, a_done_at);
          if (exp_a.size() == 0) begin
            check("a_unexpected_frame", 1, 0);
          end else begin
            a_e = exp_a.pop_front();
            check("a_frame_bits", int'(a_bits), a_e.bits);
            check("a_frame_len", a_cnt, a_e.len);
            check("a_done_pos", a_done_at, a_e.len - 1);
          end
        end
      end
    end
  end

  // ---------------- monitor B ----------------
  logic        b_cap = 1'b0;
  int          b_cnt, b_done_at;
  logic [15:0] b_bits;
  int          b_samples = 0;
  exp_t        b_e;
  always @(negedge clk) begin
    if (sample_b) b_samples++;
    if (rst_b) begin
      b_cap = 1'b0;
    end else begin
      if (!b_cap && busy_b) begin
        b_cap = 1'b1; b_cnt = 0; b_bits = '0; b_done_at = -1;
      end
      if (b_cap) begin
        if (busy_b) begin
          if ((b_cnt / B_CPB) < 16 && (b_cnt % B_CPB) == B_CPB / 2)
            b_bits[b_cnt / B_CPB] = txd_b;
          if (done_b) b_done_at = b_cnt;
          b_cnt++;
        end else begin
          b_cap = 1'b0;
          $display("frame B: bits=0x%0h len=%0d done_at=%0d", b_bits, b_cnt, b_done_at);
          if (exp_b.size() == 0) begin
            check("b_unexpected_frame", 1, 0);
          end else begin
            b_e = exp_b.pop_front();
            check("b_frame_bits", int'(b_bits), b_e.bits);
            check("b_frame_len", b_cnt, b_e.len);
            check("b_done_pos", b_done_at, b_e.len - 1);
          end
        end
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic wait_done_b(input string nm);
    int k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!done_b && k < 200);
    check(nm, int'(done_b), 1);
  endtask

  initial begin
    int k;
    int t0;
    rst_a = 1'b1; start_a = 1'b0; req_a = 1'b0; in_a = '0;
    rst_b = 1'b1; start_b = 1'b0; req_b = 1'b0; in_b = '0;
    repeat (3) step();
    @(negedge clk);
    check("a_reset_state", int'({txd_a, busy_a, sample_a, done_a, ovr_a}), 'b10000);
    check("b_reset_state", int'({txd_b, busy_b, sample_b, done_b, ovr_b}), 'b10000);
    step();
    rst_a = 1'b0; rst_b = 1'b0;
    repeat (2) step();

    // ---- A: periodic launch on uart_start rise (tx_req same cycle ignored)
    start_a = 1'b1; req_a = 1'b1; in_a = 2'b10;
    exp_a.push_back('{bits: 'b1100, len: 4 * A_CPB});
    @(negedge clk);
    check("a_sample_at_launch", int'(sample_a), 1);
    t0 = cyc;
    step();
    req_a = 1'b0; in_a = 2'b01;          // affects only the next frame
    exp_a.push_back('{bits: 'b1010, len: 4 * A_CPB});
    @(negedge clk);
    check("a_first_bit_start", int'({busy_a, txd_a}), 'b10);
    repeat (100) step();
    req_a = 1'b1;                        // ignored while uart_start=1
    step();
    req_a = 1'b0;
    @(negedge clk);
    check("a_req_ignored_no_ovr", int'(ovr_a), 0);
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (!sample_a && k < 6000);
    check("a_second_launch_seen", int'(sample_a), 1);
    check("a_period_interval", cyc - t0, 8 * A_CPB);
    // drop uart_start half way through data bit 0 of the second frame
    repeat (A_CPB + 1 + A_CPB / 2) step();
    start_a = 1'b0;
    repeat (5000) step();
    @(negedge clk);
    check("a_idle_after_stop", int'({txd_a, busy_a}), 'b10);
    check("a_launch_count", a_samples, 2);

    // ---- B: single frame on tx_req, parity + 2 stop bits
    step();
    req_b = 1'b1; in_b = 8'hA5;
    exp_b.push_back('{bits: 'hD4A, len: 12 * B_CPB});
    @(negedge clk);
    check("b_sample_at_req", int'(sample_b), 1);
    step();
    req_b = 1'b0; in_b = 8'h00;          // must not reach the line
    @(negedge clk);
    check("b_first_bit_start", int'({busy_b, txd_b}), 'b10);
    wait_done_b("b1_done_seen");
    // request on the cycle after done launches normally
    step();
    req_b = 1'b1; in_b = 8'h01;
    exp_b.push_back('{bits: 'hE02, len: 12 * B_CPB});
    @(negedge clk);
    check("b_launch_after_done", int'({sample_b, busy_b}), 'b10);
    step();
    req_b = 1'b0;
    @(negedge clk);
    check("b_no_ovr_after_done", int'(ovr_b), 0);
    // request mid-frame: dropped, sticky overrun
    repeat (10) step();
    req_b = 1'b1; in_b = 8'hFF;
    step();
    req_b = 1'b0;
    @(negedge clk);
    check("b_ovr_set_midframe", int'(ovr_b), 1);
    wait_done_b("b2_done_seen");
    repeat (5) step();
    @(negedge clk);
    check("b_ovr_sticky", int'(ovr_b), 1);

    // ---- B: one periodic launch, uart_start falls next cycle (clears overrun)
    step();
    start_b = 1'b1; in_b = 8'h3C;
    exp_b.push_back('{bits: 'hC78, len: 12 * B_CPB});
    @(negedge clk);
    check("b_sample_on_rise", int'(sample_b), 1);
    step();
    start_b = 1'b0;
    step();
    @(negedge clk);
    check("b_ovr_cleared_on_fall", int'(ovr_b), 0);
    repeat (12 * B_CPB - 2) step();      // now on the done cycle
    req_b = 1'b1;
    @(negedge clk);
    check("b_done_cycle_req", int'({done_b, sample_b}), 'b10);
    step();
    req_b = 1'b0;
    @(negedge clk);
    check("b_ovr_on_done_cycle", int'({ovr_b, busy_b}), 'b10);

    // ---- B: reset during DATA
    step();
    req_b = 1'b1; in_b = 8'hF0;
    step();
    req_b = 1'b0;
    repeat (8) step();
    rst_b = 1'b1;
    step();
    rst_b = 1'b0;
    @(negedge clk);
    check("b_reset_midframe", int'({txd_b, busy_b, ovr_b}), 'b100);
    repeat (60) step();
    @(negedge clk);
    check("b_no_resume", int'({txd_b, busy_b}), 'b10);

    // ---- B: in_data changed the cycle after latch
    step();
    req_b = 1'b1; in_b = 8'h5A;
    exp_b.push_back('{bits: 'hCB4, len: 12 * B_CPB});
    step();
    req_b = 1'b0; in_b = 8'h00;
    wait_done_b("b7_done_seen");
    repeat (100) step();
    @(negedge clk);
    check("b_launch_count", b_samples, 5);
    check("a_frames_pending", exp_a.size(), 0);
    check("b_frames_pending", exp_b.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule
